// File: rtl/pe_seq_ctrl.sv
// Issue-side sequencer for PE_core: reads K weight/vector pairs from SRAM, aligns
// alu_start/cycle_num to the read data, then captures mul_outcome and offers it downstream.
module pe_seq_ctrl #(
    parameter int unsigned ARRAY_SIZE    = 16,
    parameter int unsigned OUTCOME_WIDTH = 32,
    parameter int unsigned K_ACCUM_DEPTH = 5,
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned PE_LAT        = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [8:0]                          k_len,
    input  logic [ADDR_W-1:0]                   w_base_addr,
    input  logic [ADDR_W-1:0]                   v_base_addr,
    output logic                                busy,
    output logic                                done,
    output logic                                sram_ren_w,
    output logic [ADDR_W-1:0]                   sram_raddr_w,
    output logic                                sram_ren_v,
    output logic [ADDR_W-1:0]                   sram_raddr_v,
    output logic                                alu_start,
    output logic [8:0]                          cycle_num,
    input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
    output logic                                result_valid,
    input  logic                                result_ready,
    output logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] result_data
);

    localparam int unsigned DATA_W = ARRAY_SIZE * OUTCOME_WIDTH;
    localparam int unsigned CNT_W  = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        ALIGN = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [CNT_W-1:0]    k_q, k_n;
    logic [ADDR_W-1:0]   w_base_q, w_base_n;
    logic [ADDR_W-1:0]   v_base_q, v_base_n;
    logic                busy_n, done_n;
    logic                ren_w_n, ren_v_n;
    logic [ADDR_W-1:0]   raddr_w_n, raddr_v_n;
    logic                alu_start_n;
    logic [8:0]          cycle_num_n;
    logic                result_valid_n;
    logic                capture_c;
    logic [CNT_W-1:0]    k_eff_c;

    assign k_eff_c = (k_len > CNT_W'(K_ACCUM_DEPTH)) ? CNT_W'(K_ACCUM_DEPTH) : k_len;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            k_q          <= '0;
            w_base_q     <= '0;
            v_base_q     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sram_ren_w   <= 1'b0;
            sram_raddr_w <= '0;
            sram_ren_v   <= 1'b0;
            sram_raddr_v <= '0;
            alu_start    <= 1'b0;
            cycle_num    <= '0;
            result_valid <= 1'b0;
            result_data  <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            k_q          <= k_n;
            w_base_q     <= w_base_n;
            v_base_q     <= v_base_n;
            busy         <= busy_n;
            done         <= done_n;
            sram_ren_w   <= ren_w_n;
            sram_raddr_w <= raddr_w_n;
            sram_ren_v   <= ren_v_n;
            sram_raddr_v <= raddr_v_n;
            alu_start    <= alu_start_n;
            cycle_num    <= cycle_num_n;
            result_valid <= result_valid_n;
            if (capture_c) begin
                result_data <= mul_outcome;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        k_n            = k_q;
        w_base_n       = w_base_q;
        v_base_n       = v_base_q;
        busy_n         = busy;
        done_n         = 1'b0;
        ren_w_n        = 1'b0;
        ren_v_n        = 1'b0;
        raddr_w_n      = sram_raddr_w;
        raddr_v_n      = sram_raddr_v;
        alu_start_n    = 1'b0;
        cycle_num_n    = '0;
        result_valid_n = result_valid;
        capture_c      = 1'b0;

        case (state)
            IDLE: begin
                busy_n         = 1'b0;
                result_valid_n = 1'b0;
                if (start) begin
                    if (k_eff_c != '0) begin
                        k_n       = k_eff_c;
                        w_base_n  = w_base_addr;
                        v_base_n  = v_base_addr;
                        cnt_n     = '0;
                        ren_w_n   = 1'b1;
                        ren_v_n   = 1'b1;
                        raddr_w_n = w_base_addr;
                        raddr_v_n = v_base_addr;
                        busy_n    = 1'b1;
                        state_n   = READ;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            READ: begin
                // Read data for step cnt arrives next cycle, so the step is issued then
                alu_start_n = 1'b1;
                cycle_num_n = cnt;
                if (cnt == k_q - CNT_W'(1)) begin
                    cnt_n   = '0;
                    state_n = ALIGN;
                end else begin
                    cnt_n     = cnt + CNT_W'(1);
                    ren_w_n   = 1'b1;
                    ren_v_n   = 1'b1;
                    raddr_w_n = w_base_q + ADDR_W'(cnt + CNT_W'(1));
                    raddr_v_n = v_base_q + ADDR_W'(cnt + CNT_W'(1));
                end
            end
            ALIGN: begin
                cnt_n   = '0;
                state_n = DRAIN;
            end
            DRAIN: begin
                if (cnt == CNT_W'(PE_LAT)) begin
                    capture_c      = 1'b1;
                    result_valid_n = 1'b1;
                    cnt_n          = '0;
                    state_n        = OUT;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            OUT: begin
                if (result_ready) begin
                    result_valid_n = 1'b0;
                    busy_n         = 1'b0;
                    done_n         = 1'b1;
                    state_n        = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    logic unused_c;
    assign unused_c = ^{DATA_W};

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl with an SRAM + PE_core behavioural model and a result scoreboard.
module tb_pe_seq_ctrl;

    localparam int unsigned AS = 16;
    localparam int unsigned DW = 512;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [8:0]      k_len;
    logic [9:0]      w_base_addr;
    logic [9:0]      v_base_addr;
    logic            busy;
    logic            done;
    logic            sram_ren_w;
    logic [9:0]      sram_raddr_w;
    logic            sram_ren_v;
    logic [9:0]      sram_raddr_v;
    logic            alu_start;
    logic [8:0]      cycle_num;
    logic [DW-1:0]   mul_outcome = '0;
    logic            result_valid;
    logic            result_ready;
    logic [DW-1:0]   result_data;

    int errors = 0;
    int checks = 0;
    int vmem [1024];
    int wsc  [1024];
    logic [DW-1:0] sb [$];
    logic [DW-1:0] last_result;
    int cur_w = 0;
    int cur_v = 0;

    always #5 clk = ~clk;

    pe_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .w_base_addr(w_base_addr), .v_base_addr(v_base_addr),
        .busy(busy), .done(done),
        .sram_ren_w(sram_ren_w), .sram_raddr_w(sram_raddr_w),
        .sram_ren_v(sram_ren_v), .sram_raddr_v(sram_raddr_v),
        .alu_start(alu_start), .cycle_num(cycle_num),
        .mul_outcome(mul_outcome),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_data(result_data)
    );

    function automatic int w_of(int a, int l);
        return (l + 1) * wsc[a];
    endfunction

    // Value m/2 as fp32 bits (exact for small m)
    function automatic logic [31:0] fp_halves(int m);
        int p = 0;
        int e;
        if (m == 0) return 32'h0;
        for (int b = 0; b < 24; b++) if (((m >> b) & 1) == 1) p = b;
        e = 127 + p - 1;
        return {1'b0, 8'(e), 23'((m << (23 - p)) & 32'h007F_FFFF)};
    endfunction

    function automatic logic [DW-1:0] exp_result(int wb, int vb, int k);
        logic [DW-1:0] r = '0;
        for (int l = 0; l < AS; l++) begin
            int acc = 0;
            for (int c = 0; c < k; c++)
                acc += w_of((wb + c) & 1023, l) * vmem[(vb + c) & 1023];
            r[DW-1-32*l -: 32] = fp_halves(acc);
        end
        return r;
    endfunction

    // SRAM (1-cycle latency) and PE_core model: mul_outcome is valid for exactly one cycle
    logic [9:0] rw_a = '0;
    logic [9:0] rv_a = '0;
    int         acc [AS];
    logic       step_d = 1'b0;

    function automatic logic [DW-1:0] pack_acc();
        logic [DW-1:0] r = '0;
        for (int l = 0; l < AS; l++) r[DW-1-32*l -: 32] = fp_halves(acc[l]);
        return r;
    endfunction

    always @(posedge clk) begin
        if (sram_ren_w) rw_a <= sram_raddr_w;
        if (sram_ren_v) rv_a <= sram_raddr_v;
        if (alu_start)
            for (int l = 0; l < AS; l++)
                acc[l] <= ((cycle_num == 9'd0) ? 0 : acc[l]) + w_of(int'(rw_a), l) * vmem[int'(rv_a)];
        step_d      <= alu_start;
        mul_outcome <= (step_d && !alu_start) ? pack_acc() : {AS{32'hDEAD_BEEF}};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in a cycle where the DUT is idle; returns in the done cycle.
    task automatic run_job(input int kl, input int wb, input int vb, input int rd, input bit hold);
        int k    = (kl > 5) ? 5 : kl;
        int v    = k + 4;
        int last = (k == 0) ? 1 : v + rd + 1;
        if (k > 0) sb.push_back(exp_result(wb, vb, k));
        start        = 1'b1;
        k_len        = 9'(kl);
        w_base_addr  = 10'(wb);
        v_base_addr  = 10'(vb);
        result_ready = 1'b0;
        for (int n = 1; n <= last; n++) begin
            bit e_ren, e_alu, e_val, e_busy, e_done;
            tick();
            if (!hold) begin
                start       = 1'b0;
                k_len       = 9'($urandom_range(0, 511));
                w_base_addr = 10'($urandom);
                v_base_addr = 10'($urandom);
            end
            result_ready = (n >= v + rd);
            e_ren  = (k > 0) && (n <= k);
            e_alu  = (k > 0) && (n >= 2) && (n <= k + 1);
            e_val  = (k > 0) && (n >= v) && (n <= v + rd);
            e_busy = (k > 0) && (n <= v + rd);
            e_done = (n == last);
            if (e_ren) begin
                cur_w = (wb + n - 1) & 1023;
                cur_v = (vb + n - 1) & 1023;
            end
            check("ren_w", 32'(sram_ren_w), 32'(e_ren));
            check("ren_v", 32'(sram_ren_v), 32'(e_ren));
            check("raddr_w", 32'(sram_raddr_w), 32'(cur_w));
            check("raddr_v", 32'(sram_raddr_v), 32'(cur_v));
            check("alu_start", 32'(alu_start), 32'(e_alu));
            check("cycle_num", 32'(cycle_num), e_alu ? 32'(n - 2) : 32'h0);
            check("result_valid", 32'(result_valid), 32'(e_val));
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            if (e_val && sb.size() > 0) begin
                checks++;
                assert (result_data === sb[0]) else begin
                    errors++;
                    $error("FAIL result_data cycle=%0d observed=%h expected=%h", n, result_data, sb[0]);
                end
                if (n == v + rd) begin
                    last_result = result_data;
                    void'(sb.pop_front());
                end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) begin
            vmem[a] = (a * 3) % 5 + 1;
            wsc[a]  = a % 3 + 1;
        end
        for (int i = 0; i < 5; i++) begin
            wsc[16 + i]  = 1;
            vmem[32 + i] = i + 1;
        end
        rst = 1'b1; start = 1'b0; k_len = '0; w_base_addr = '0; v_base_addr = '0; result_ready = 1'b0;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_valid", 32'(result_valid), 32'h0);
        check("rst_raddr_w", 32'(sram_raddr_w), 32'h0);
        check("rst_data_lane0", result_data[DW-1 -: 32], 32'h0);
        rst = 1'b0;
        tick();

        // Nominal job; lane 0 = 1.0 * (0.5+1+1.5+2+2.5) = 7.5
        run_job(5, 'h010, 'h020, 0, 1'b0);
        check("nominal_lane0", last_result[DW-1 -: 32], 32'h40F0_0000);
        check("nominal_lane15", last_result[31:0], 32'h42F0_0000);
        start = 1'b0; tick();

        run_job(4, 'h100, 'h200, 4, 1'b0);      // backpressure
        start = 1'b0; tick();
        run_job(0, 'h055, 'h066, 0, 1'b0);      // empty job
        start = 1'b0; tick();
        run_job(9, 'h033, 'h044, 0, 1'b0);      // clamped to 5
        start = 1'b0; tick();
        run_job(4, 'h3FE, 'h3FD, 1, 1'b0);      // address wrap
        run_job(5, 'h080, 'h090, 2, 1'b1);      // back-to-back with start held
        run_job(2, 'h085, 'h1F0, 0, 1'b0);
        start = 1'b0; tick();

        // Reset during READ: nothing from this job may ever appear
        start = 1'b1; k_len = 9'd5; w_base_addr = 10'h040; v_base_addr = 10'h050; result_ready = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_ren_w", 32'(sram_ren_w), 32'h0);
        check("midrst_raddr_w", 32'(sram_raddr_w), 32'h0);
        check("midrst_raddr_v", 32'(sram_raddr_v), 32'h0);
        check("midrst_alu", 32'(alu_start), 32'h0);
        rst = 1'b0;
        cur_w = 0; cur_v = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("midrst_no_valid", 32'(result_valid), 32'h0);
            check("midrst_no_done", 32'(done), 32'h0);
        end

        run_job(5, 'h010, 'h020, 0, 1'b0);
        check("post_rst_lane0", last_result[DW-1 -: 32], 32'h40F0_0000);
        start = 1'b0; tick();
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
